// File: rtl/serial_subtractor_if.sv
// Start/done request bundle for the bit-serial subtractor.
// master drives start/A/B; slave returns busy/done/D/bout/ovf/zero.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start,
    output A,
    output B,
    input  busy,
    input  done,
    input  D,
    input  bout,
    input  ovf,
    input  zero
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output busy,
    output done,
    output D,
    output bout,
    output ovf,
    output zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, one bit per clock, LSB first.
// Ports: Clk, Reset_n (async low), bus (slave: start/A/B in; busy/done/D/bout/ovf/zero out).
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_amsb;
  logic             r_bmsb;

  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_sr_next;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_shift   = (r_state == S_SHIFT);
  assign w_last    = w_shift && (r_cnt == LAST);

  // Full-adder cell; SB already holds ~B and c starts at 1.
  assign w_s       = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_cout    = (r_sa[0] & r_sb[0])
                   | (r_sa[0] & r_c)
                   | (r_sb[0] & r_c);
  assign w_sr_next = {w_s, r_sr[WIDTH-1:1]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sr   <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
    end else if (w_accept) begin
      r_sa   <= bus.A;
      r_sb   <= ~bus.B;
      r_sr   <= '0;
      r_c    <= 1'b1;
      r_cnt  <= '0;
      r_amsb <= bus.A[WIDTH-1];
      r_bmsb <= bus.B[WIDTH-1];
    end else if (w_shift) begin
      r_sa   <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb   <= {1'b0, r_sb[WIDTH-1:1]};
      r_sr   <= w_sr_next;
      r_c    <= w_cout;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Result registers move only on the completion edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_d    <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_d    <= w_sr_next;
      r_bout <= ~w_cout;
      r_ovf  <= (r_amsb ^ r_bmsb)
              & (w_sr_next[WIDTH-1] ^ r_amsb);
      r_zero <= (w_sr_next == '0);
    end
  end

  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = (r_state == S_DONE);
  assign bus.D    = r_d;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;

endmodule
